pwm_ramp_ctrl: RTL and testbench
================================

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, width of duty, period and all counters.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid  input  1  new target command present.
REQ-005 SHALL have port cmd_ready  output  1  controller can accept a command.
REQ-006 SHALL have port cmd_duty  input  W  target duty, in clocks high per frame.
REQ-007 SHALL have port cmd_period  input  W  target frame length; 0 means 2^W clocks.
REQ-008 SHALL have port ramp_step  input  W  duty change per step; 0 means jump directly to target.
REQ-009 SHALL have port ramp_div  input  W  number of extra frames between steps: one step every ramp_div+1 frames.
REQ-010 SHALL have port stop  input  1  abort: force duty to 0 and return to idle.
REQ-011 SHALL have port duty  output  W  duty value driven to the PWM generator.
REQ-012 SHALL have port period  output  W  period value driven to the PWM generator.
REQ-013 SHALL have port frame_start  output  1  one-cycle pulse when the frame counter wraps to 0.
REQ-014 SHALL have port busy  output  1  high while in RAMP.
REQ-015 SHALL have port done  output  1  one-cycle pulse when the target is reached.

Function
REQ-016 SHALL keep an internal W-bit frame counter: clears when count >= period-1 (W-bit arithmetic), otherwise increments; frame_start is registered and asserts on the cycle the counter wraps to 0.
REQ-017 SHALL define a frame boundary as the clock edge at which the counter wraps; period=1 gives a boundary every clock; period=0 gives a 2^W-clock frame.
REQ-018 SHALL implement states IDLE, RAMP and HOLD: IDLE is entered on reset or stop; RAMP is entered on command accept; RAMP moves to HOLD when duty equals the target; HOLD moves to RAMP on the next command accept.
REQ-019 SHALL register cmd_ready: 1 in IDLE and HOLD, 0 in RAMP, and 0 in the cycle after an accept.
REQ-020 SHALL accept a command on cycle T when cmd_valid & cmd_ready: latch cmd_duty, cmd_period, ramp_step and ramp_div; clamp the target duty to cmd_period when cmd_duty > cmd_period and cmd_period != 0.
REQ-021 SHALL update duty and period only at frame boundaries, never mid-frame.
REQ-022 SHALL load period from the latched target at the first boundary after accept (the load boundary) and clear the step-divider counter there; duty is unchanged at the load boundary.
REQ-023 SHALL step duty at each later boundary where the divider equals the latched ramp_div, then clear the divider; at other boundaries the divider increments.
REQ-024 SHALL compute each step as duty ± min(step, |target-duty|) in W+1-bit arithmetic, with no overshoot and no wrap.
REQ-025 SHALL, when the latched ramp_step = 0, set duty to the target at the load boundary and pulse done in that same cycle.
REQ-026 SHALL pulse done in the cycle duty reaches the target, then enter HOLD; a command whose target equals the current duty completes at the load boundary.
REQ-027 SHALL, on stop, set duty to 0 at the next boundary and enter IDLE; period is unchanged and done is not pulsed.
REQ-028 SHALL give stop priority over a command accept in the same cycle; cmd_ready is 0 while stop is high.

Reset
REQ-029 SHALL, while rst is high, asynchronously force: duty=0, period=2^W-1, counter=0, frame_start=0, busy=0, done=0, cmd_ready=0, state=IDLE.
REQ-030 SHALL assert cmd_ready in the first cycle after rst deasserts; a reset during RAMP discards the latched target.

Structure
REQ-031 SHALL place the state encoding (IDLE/RAMP/HOLD) and W default in a shared package (pwm_pkg).
REQ-032 SHALL contain no sub-modules; the frame counter is inline and mirrors the generator's wrap rule; the top level instantiates pwm beside this block.

Verification
REQ-033 SHALL cover: period=100, cmd_duty=50, step=10, div=0 from reset -> period=100 at load boundary; duty=10,20,30,40,50 at the next 5 boundaries; done at the fifth; cmd_ready=1 after.
REQ-034 SHALL cover: from HOLD at 50, cmd_duty=5, step=10, div=1 -> duty=40,30,20,10,5, one step every 2 frames, no undershoot.
REQ-035 SHALL cover: step=0, cmd_duty=200, period=100 -> duty=100 (clamped) at the load boundary; done in the same cycle.
REQ-036 SHALL cover: stop asserted with cmd_valid while duty=30 mid-ramp -> no accept; duty=0 at next boundary; state IDLE; no done.
REQ-037 SHALL cover: rst pulse mid-frame during RAMP -> duty=0, period=255 immediately (asynchronous); cmd_ready=1 one cycle after release.
REQ-038 SHALL cover: period=1 and period=0 -> frame_start every clock, and every 256 clocks, respectively.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp controller: default width and FSM state encoding.
package pwm_pkg;

    localparam int W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_ramp_ctrl.sv
// Ramps the duty/period fed to a PWM generator toward a commanded target,
// changing them only at frame boundaries of a mirrored frame counter.
//
// state | meaning
// IDLE  | no target held; accepting commands
// RAMP  | stepping duty toward the latched target at frame boundaries
// HOLD  | target reached; accepting commands
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_duty,
    input  logic [W-1:0] cmd_period,
    input  logic [W-1:0] ramp_step,
    input  logic [W-1:0] ramp_div,
    input  logic         stop,
    output logic [W-1:0] duty,
    output logic [W-1:0] period,
    output logic         frame_start,
    output logic         busy,
    output logic         done
);

    state_t         r_state;
    state_t         w_state_nxt;

    logic [W-1:0]   r_cnt;
    logic [W-1:0]   r_duty;
    logic [W-1:0]   r_period;
    logic [W-1:0]   r_tgt_duty;
    logic [W-1:0]   r_tgt_period;
    logic [W-1:0]   r_step;
    logic [W-1:0]   r_div;
    logic [W-1:0]   r_div_cnt;
    logic           r_frame_start;
    logic           r_done;
    logic           r_ready;
    logic           r_load_pend;
    logic           r_zero_pend;

    logic           w_wrap;
    logic           w_accept;
    logic           w_up;
    logic           w_step_now;
    logic           w_reach;
    logic           w_ramp_bnd;
    logic [W-1:0]   w_clamped;
    logic [W:0]     w_diff;
    logic [W:0]     w_inc;
    logic [W:0]     w_stepped;

    // Same wrap rule as the generator: period 0 wraps at 2^W-1, i.e. a 2^W frame.
    assign w_wrap     = (r_cnt >= (r_period - W'(1)));
    assign w_accept   = cmd_valid & r_ready & ~stop;
    assign w_clamped  = ((cmd_duty > cmd_period) && (cmd_period != '0)) ? cmd_period : cmd_duty;

    assign w_up       = (r_tgt_duty > r_duty);
    assign w_diff     = w_up ? ({1'b0, r_tgt_duty} - {1'b0, r_duty})
                             : ({1'b0, r_duty} - {1'b0, r_tgt_duty});
    assign w_inc      = ({1'b0, r_step} < w_diff) ? {1'b0, r_step} : w_diff;
    assign w_stepped  = w_up ? ({1'b0, r_duty} + w_inc) : ({1'b0, r_duty} - w_inc);
    assign w_step_now = ~r_load_pend && (r_div_cnt == r_div);
    assign w_reach    = r_load_pend ? ((r_step == '0) || (r_duty == r_tgt_duty))
                                    : (w_step_now && (w_stepped == {1'b0, r_tgt_duty}));
    assign w_ramp_bnd = (r_state == ST_RAMP) && !stop && w_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_HOLD: begin
                if (w_accept) begin
                    w_state_nxt = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (w_wrap && w_reach) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (stop) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        busy = (r_state == ST_RAMP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_wrap;
            if (w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty       <= '0;
            r_period     <= '1;
            r_tgt_duty   <= '0;
            r_tgt_period <= '0;
            r_step       <= '0;
            r_div        <= '0;
            r_div_cnt    <= '0;
            r_done       <= 1'b0;
            r_ready      <= 1'b0;
            r_load_pend  <= 1'b0;
            r_zero_pend  <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_ready <= (w_state_nxt != ST_RAMP);

            if (w_accept) begin
                r_tgt_duty   <= w_clamped;
                r_tgt_period <= cmd_period;
                r_step       <= ramp_step;
                r_div        <= ramp_div;
                r_load_pend  <= 1'b1;
            end

            // A stop on a boundary edge zeroes duty right away; otherwise at the next one.
            if (stop) begin
                r_load_pend <= 1'b0;
                r_zero_pend <= ~w_wrap;
            end else if (w_wrap) begin
                r_zero_pend <= 1'b0;
            end

            if (w_wrap && (stop || r_zero_pend)) begin
                r_duty <= '0;
            end

            if (w_ramp_bnd) begin
                if (r_load_pend) begin
                    r_period    <= r_tgt_period;
                    r_div_cnt   <= '0;
                    r_load_pend <= 1'b0;
                    if (w_reach) begin
                        r_duty <= r_tgt_duty;
                        r_done <= 1'b1;
                    end
                end else if (w_step_now) begin
                    r_duty    <= w_stepped[W-1:0];
                    r_div_cnt <= '0;
                    if (w_reach) begin
                        r_done <= 1'b1;
                    end
                end else begin
                    r_div_cnt <= r_div_cnt + W'(1);
                end
            end
        end
    end

    assign cmd_ready   = r_ready & ~stop;
    assign duty        = r_duty;
    assign period      = r_period;
    assign frame_start = r_frame_start;
    assign done        = r_done;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed self-checking bench for pwm_ramp_ctrl: ramp up/down, jump with clamp,
// stop abort, asynchronous reset mid-ramp and the period=1 / period=0 frame extremes.
module tb_pwm_ramp_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_duty;
    logic [W-1:0] cmd_period;
    logic [W-1:0] ramp_step;
    logic [W-1:0] ramp_div;
    logic         stop;
    logic [W-1:0] duty;
    logic [W-1:0] period;
    logic         frame_start;
    logic         busy;
    logic         done;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int n;
    int base;
    logic [7:0] exp_down [10] = '{8'd50, 8'd40, 8'd40, 8'd30, 8'd30,
                                  8'd20, 8'd20, 8'd10, 8'd10, 8'd5};

    pwm_ramp_ctrl #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_duty    (cmd_duty),
        .cmd_period  (cmd_period),
        .ramp_step   (ramp_step),
        .ramp_div    (ramp_div),
        .stop        (stop),
        .duty        (duty),
        .period      (period),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Ticks until frame_start is seen (boundary just happened) or the budget runs out.
    task automatic wait_frame(input int max, input string tag, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (frame_start !== 1'b1 && cnt < max);
        chk({tag, "_frame_seen"}, {31'd0, frame_start}, 32'd1);
    endtask

    task automatic send_cmd(input string tag, input logic [W-1:0] d, input logic [W-1:0] p,
                            input logic [W-1:0] s, input logic [W-1:0] dv);
        cmd_duty   = d;
        cmd_period = p;
        ramp_step  = s;
        ramp_div   = dv;
        cmd_valid  = 1'b1;
        chk({tag, "_ready_before"}, {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid  = 1'b0;
        chk({tag, "_ready_after"}, {31'd0, cmd_ready}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; stop = 1'b0;
        cmd_duty = '0; cmd_period = '0; ramp_step = '0; ramp_div = '0;
        #1 rst = 1'b1;
        tick();
        tick();
        chk("rst_duty",   duty, 0);
        chk("rst_period", period, 255);
        chk("rst_fs",     {31'd0, frame_start}, 0);
        chk("rst_busy",   {31'd0, busy}, 0);
        chk("rst_done",   {31'd0, done}, 0);
        chk("rst_ready",  {31'd0, cmd_ready}, 0);
        #3 rst = 1'b0;
        tick();
        chk("rel_ready", {31'd0, cmd_ready}, 1);

        // Ramp up 0 -> 50 by 10, one step per frame.
        send_cmd("up", 8'd50, 8'd100, 8'd10, 8'd0);
        chk("up_busy", {31'd0, busy}, 1);
        wait_frame(300, "up_load", n);
        chk("up_load_period", period, 100);
        chk("up_load_duty",   duty, 0);
        chk("up_load_done",   {31'd0, done}, 0);
        for (int i = 1; i <= 5; i++) begin
            wait_frame(120, "up_step", n);
            chk("up_frame_len", n, 100);
            chk("up_duty", duty, 10 * i);
            chk("up_done", {31'd0, done}, (i == 5) ? 1 : 0);
        end
        chk("up_ready_hold", {31'd0, cmd_ready}, 1);
        tick();
        chk("up_done_pulse", {31'd0, done}, 0);
        chk("up_hold_busy",  {31'd0, busy}, 0);

        // Ramp down 50 -> 5, one step every two frames, no undershoot.
        send_cmd("dn", 8'd5, 8'd100, 8'd10, 8'd1);
        wait_frame(120, "dn_load", n);
        chk("dn_load_duty", duty, 50);
        for (int k = 0; k < 10; k++) begin
            wait_frame(120, "dn_step", n);
            chk("dn_duty", duty, {24'd0, exp_down[k]});
            chk("dn_done", {31'd0, done}, (k == 9) ? 1 : 0);
        end

        // Direct jump with clamp to period.
        send_cmd("jmp", 8'd200, 8'd100, 8'd0, 8'd0);
        wait_frame(120, "jmp_load", n);
        chk("jmp_duty",  duty, 100);
        chk("jmp_done",  {31'd0, done}, 1);
        chk("jmp_busy",  {31'd0, busy}, 0);
        chk("jmp_ready", {31'd0, cmd_ready}, 1);

        // Stop with a simultaneous command while ramping at duty 30.
        send_cmd("stp", 8'd0, 8'd100, 8'd35, 8'd0);
        wait_frame(120, "stp_load", n);
        chk("stp_load_duty", duty, 100);
        wait_frame(120, "stp_s1", n);
        chk("stp_s1_duty", duty, 65);
        wait_frame(120, "stp_s2", n);
        chk("stp_s2_duty", duty, 30);
        chk("stp_s2_busy", {31'd0, busy}, 1);
        repeat (10) tick();
        base = done_cnt;
        stop = 1'b1; cmd_valid = 1'b1;
        cmd_duty = 8'd77; cmd_period = 8'd50; ramp_step = 8'd0; ramp_div = 8'd0;
        #1;
        chk("stp_ready_low", {31'd0, cmd_ready}, 0);
        tick();
        stop = 1'b0; cmd_valid = 1'b0;
        chk("stp_idle_busy", {31'd0, busy}, 0);
        chk("stp_mid_duty",  duty, 30);
        wait_frame(120, "stp_bnd", n);
        chk("stp_duty_zero", duty, 0);
        chk("stp_period",    period, 100);
        chk("stp_no_done",   done_cnt - base, 0);
        chk("stp_ready",     {31'd0, cmd_ready}, 1);

        // Asynchronous reset in the middle of a ramp frame.
        send_cmd("ar", 8'd90, 8'd100, 8'd10, 8'd0);
        wait_frame(120, "ar_load", n);
        chk("ar_load_duty", duty, 0);
        wait_frame(120, "ar_s1", n);
        chk("ar_s1_duty", duty, 10);
        chk("ar_s1_busy", {31'd0, busy}, 1);
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        chk("ar_duty",   duty, 0);
        chk("ar_period", period, 255);
        chk("ar_ready",  {31'd0, cmd_ready}, 0);
        chk("ar_busy",   {31'd0, busy}, 0);
        #1 rst = 1'b0;
        tick();
        chk("ar_rel_ready", {31'd0, cmd_ready}, 1);
        base = done_cnt;
        wait_frame(300, "ar_after", n);
        chk("ar_frame_len", n, 254);
        chk("ar_after_duty",   duty, 0);
        chk("ar_after_busy",   {31'd0, busy}, 0);
        chk("ar_after_period", period, 255);
        chk("ar_after_done",   done_cnt - base, 0);

        // Frame extremes: period 1 then period 0 (2^W clocks).
        send_cmd("p1", 8'd1, 8'd1, 8'd0, 8'd0);
        wait_frame(300, "p1_load", n);
        chk("p1_period", period, 1);
        chk("p1_duty",   duty, 1);
        chk("p1_done",   {31'd0, done}, 1);
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("p1_fs_every_clk", {31'd0, frame_start}, 1);
        end
        send_cmd("p0", 8'd0, 8'd0, 8'd0, 8'd0);
        wait_frame(10, "p0_load", n);
        chk("p0_load_delay", n, 1);
        chk("p0_period", period, 0);
        chk("p0_duty",   duty, 0);
        for (int j = 0; j < 2; j++) begin
            wait_frame(300, "p0_frame", n);
            chk("p0_frame_len", n, 256);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
